enigma_ctrl: RTL and testbench
==============================

# enigma_ctrl

Initiator-side sequencer for one rotor slice. It accepts plaintext or ciphertext characters on a valid/ready stream and loads configuration into the rotor. For each character it drives the rotor's set/valid/en/dec handshake, waits for the rotor's done, and returns the rotor's output character on a valid/ready result stream. It sits between the character I/O front end and a rotor instance, and owns all rotor-side sequencing, timeouts and input validation.

## Interface
Parameters:
- TIMEOUT, 64: maximum WAIT cycles for r_done before the character is failed (legal range 2..65535).

Ports. One clock; reset is asynchronous and active-low.
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- cfg_load  in  1  single-cycle request to load the cfg_* values
- cfg_offset  in  32  rotor step per en cycle
- cfg_delay  in  32  rotor delay count
- cfg_idx  in  208  rotor wiring, 26 x 8-bit
- cfg_dec  in  1  0 = encode, 1 = decode
- in_valid  in  1  input character valid
- in_ready  out  1  controller accepts in_char
- in_char  in  8  ASCII input character
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_char  out  8  result character
- out_err  out  1  result is an error (bad character or timeout)
- r_set, r_valid, r_en, r_rot, r_dec  out  1 each  rotor controls
- r_din  out  8  rotor input character
- r_offset, r_delay  out  32 each  rotor configuration
- r_idx  out  208  rotor wiring
- r_dout  in  8  rotor output character
- r_done  in  1  rotor result strobe

## Operation
- States:
  - IDLE: waiting for configuration or a character.
  - CFG: drives the configuration into the rotor.
  - SEND: presents the character to the rotor.
  - WAIT: steps the rotor and waits for its result.
  - OUT: holds the result for downstream.
- The cfg_* values are registered on cfg_load only in IDLE. cfg_load in any other state is ignored.
  - r_offset, r_delay, r_idx and r_dec are driven continuously from these registers.
  - cfg_ok is set in CFG and cleared only by reset.
- IDLE -> CFG when cfg_load = 1. CFG lasts 1 cycle with r_set = 1, then returns to IDLE.
- in_ready = (state == IDLE) && cfg_ok && !cfg_load. cfg_load beats in_valid in the same cycle.
- Accept (in_valid && in_ready):
  - in_char in 65..90: the character is latched and the block goes to SEND.
  - Any other in_char: the block goes to OUT with out_char = in_char and out_err = 1. No rotor signals toggle.
- SEND lasts 1 cycle: r_valid = 1, r_din = latched character. Then WAIT.
- WAIT:
  - r_en = 1 on every WAIT cycle.
  - wait_cnt starts at 1 and increments per cycle.
  - r_done = 1: out_char <= r_dout, out_err <= 0, go to OUT.
  - Else if wait_cnt == TIMEOUT: out_char <= 0, out_err <= 1, go to OUT.
- OUT: out_valid = 1 with out_char and out_err stable until out_ready = 1. Then IDLE.
- r_done outside WAIT is ignored. r_din holds its last value except during SEND, where it shows the new character. r_rot is tied to 0.

## Timing
- Reset value of every output is 0, including r_offset, r_delay, r_idx and r_dec; in_ready is also 0 because cfg_ok = 0.
- All outputs are Moore: decoded from registered state and registered data. No input-to-output path except in_ready depending on cfg_load.
- Accept at edge E:
  - SEND occupies cycle E+1.
  - The first WAIT cycle is E+2.
  - r_done seen at edge E+2+n (n >= 0) gives out_valid from cycle E+3+n.
  - Minimum accept-to-out_valid is 3 cycles.
- Timeout: out_valid is asserted TIMEOUT+2 cycles after accept.
- out_ready high while out_valid is high: the transfer completes at that edge. in_ready may rise the next cycle. Throughput is at most 1 char per 4 cycles.
- Reset mid-operation: immediate return to IDLE. Outputs are 0, cfg_ok = 0, and any partial result is discarded.

## Configuration
- ENIGMA_CTRL_STATS_EN defined:
  - Adds outputs char_count (16 bit) and err_count (16 bit).
  - char_count increments on every completed out transfer.
  - err_count increments on transfers with out_err = 1.
  - Both saturate at 16'hFFFF and reset to 0.
- Not defined: these ports and counters do not exist. Behaviour is otherwise identical.

## Test plan
- Reset, then in_valid = 1 before any cfg_load -> in_ready stays 0 and no r_valid pulse.
- cfg_load with offset = 1, delay = 3, cfg_dec = 0 -> r_set high for exactly 1 cycle, r_offset = 1, r_delay = 3; then in_ready = 1.
- Accept 'A' (65) with a rotor model raising r_done after 2 WAIT cycles with r_dout = 8'h45 -> r_valid for 1 cycle, r_en for 3 cycles, out_char = 8'h45, out_err = 0, out_valid 5 cycles after accept.
- in_char = 8'h61 ('a') -> out_err = 1, out_char = 8'h61, no r_valid or r_en activity.
- Rotor never asserts r_done, TIMEOUT = 8 -> out_err = 1, out_char = 0, out_valid 10 cycles after accept.
- out_ready held 0 for 5 cycles during OUT -> out_char and out_err stable and in_ready = 0. Then reset_n pulsed low in WAIT -> all outputs 0 and a cfg_load is required again.

Source files
------------

// File: rtl/enigma_ctrl.sv
// Initiator-side sequencer driving one rotor slice from a character stream.
// Optional transfer/error counters: define ENIGMA_CTRL_STATS_EN.
module enigma_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cfg_load,
    input  logic [31:0]  cfg_offset,
    input  logic [31:0]  cfg_delay,
    input  logic [207:0] cfg_idx,
    input  logic         cfg_dec,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_char,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_char,
    output logic         out_err,
    output logic         r_set,
    output logic         r_valid,
    output logic         r_en,
    output logic         r_rot,
    output logic         r_dec,
    output logic [7:0]   r_din,
    output logic [31:0]  r_offset,
    output logic [31:0]  r_delay,
    output logic [207:0] r_idx,
    input  logic [7:0]   r_dout,
    input  logic         r_done
`ifdef ENIGMA_CTRL_STATS_EN
    ,
    output logic [15:0]  char_count,
    output logic [15:0]  err_count
`endif
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] CFG  = 3'd1;
    localparam logic [2:0] SEND = 3'd2;
    localparam logic [2:0] WAIT = 3'd3;
    localparam logic [2:0] OUT  = 3'd4;

    localparam logic [15:0] TMO = 16'(TIMEOUT);

    logic [2:0]  state;
    logic        cfg_ok;
    logic [15:0] wait_cnt;
    logic        accept;
    logic        is_upper;

    assign in_ready  = (state == IDLE) && cfg_ok && !cfg_load;
    assign accept    = in_valid && in_ready;
    assign is_upper  = (in_char >= 8'd65) && (in_char <= 8'd90);

    assign r_set     = (state == CFG);
    assign r_valid   = (state == SEND);
    assign r_en      = (state == WAIT);
    assign out_valid = (state == OUT);
    assign r_rot     = 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cfg_ok   <= 1'b0;
            wait_cnt <= 16'd0;
            r_offset <= 32'd0;
            r_delay  <= 32'd0;
            r_idx    <= 208'd0;
            r_dec    <= 1'b0;
            r_din    <= 8'd0;
            out_char <= 8'd0;
            out_err  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cfg_load) begin
                        r_offset <= cfg_offset;
                        r_delay  <= cfg_delay;
                        r_idx    <= cfg_idx;
                        r_dec    <= cfg_dec;
                        state    <= CFG;
                    end else if (accept) begin
                        if (is_upper) begin
                            r_din <= in_char;
                            state <= SEND;
                        end else begin
                            // rejected characters bypass the rotor entirely
                            out_char <= in_char;
                            out_err  <= 1'b1;
                            state    <= OUT;
                        end
                    end
                end
                CFG: begin
                    cfg_ok <= 1'b1;
                    state  <= IDLE;
                end
                SEND: begin
                    wait_cnt <= 16'd1;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (r_done) begin
                        out_char <= r_dout;
                        out_err  <= 1'b0;
                        state    <= OUT;
                    end else if (wait_cnt == TMO) begin
                        out_char <= 8'd0;
                        out_err  <= 1'b1;
                        state    <= OUT;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                OUT: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ENIGMA_CTRL_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            char_count <= 16'd0;
            err_count  <= 16'd0;
        end else if (out_valid && out_ready) begin
            if (char_count != 16'hFFFF) char_count <= char_count + 16'd1;
            if (out_err && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_enigma_ctrl.sv
// Directed self-checking bench for enigma_ctrl (TIMEOUT = 8).
module tb_enigma_ctrl;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         cfg_load;
    logic [31:0]  cfg_offset;
    logic [31:0]  cfg_delay;
    logic [207:0] cfg_idx;
    logic         cfg_dec;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_char;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_char;
    logic         out_err;
    logic         r_set, r_valid, r_en, r_rot, r_dec;
    logic [7:0]   r_din;
    logic [31:0]  r_offset, r_delay;
    logic [207:0] r_idx;
    logic [7:0]   r_dout;
    logic         r_done;

    int checks = 0;
    int fails  = 0;
    int k, nv, ne;
    logic [7:0]   hold_c;
    logic         hold_e;
    logic [207:0] idx_pat;

    enigma_ctrl #(.TIMEOUT(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_load(cfg_load), .cfg_offset(cfg_offset),
        .cfg_delay(cfg_delay), .cfg_idx(cfg_idx), .cfg_dec(cfg_dec),
        .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_char(out_char), .out_err(out_err),
        .r_set(r_set), .r_valid(r_valid), .r_en(r_en),
        .r_rot(r_rot), .r_dec(r_dec), .r_din(r_din),
        .r_offset(r_offset), .r_delay(r_delay), .r_idx(r_idx),
        .r_dout(r_dout), .r_done(r_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [207:0] got,
                       input logic [207:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ctl"},
            {192'd0, in_ready, out_valid, out_err, r_set, r_valid,
             r_en, r_rot, r_dec, out_char, r_din}, 208'd0);
        chk({tag, " cfg"}, {144'd0, r_offset, r_delay}, 208'd0);
        chk({tag, " idx"}, r_idx, 208'd0);
    endtask

    task automatic accept(input logic [7:0] c);
        in_valid = 1'b1;
        in_char  = c;
        step();
        in_valid = 1'b0;
    endtask

    // Runs until out_valid; returns cycle number of out_valid (SEND = 1).
    task automatic run_char(input int done_at, input logic [7:0] dout);
        k = 1; nv = 0; ne = 0;
        while (!out_valid && k < 40) begin
            if (r_valid) nv++;
            if (r_en) begin
                ne++;
                r_done = (ne == done_at);
                r_dout = dout;
            end else r_done = 1'b0;
            step();
            k++;
        end
        r_done = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; cfg_load = 1'b0; cfg_offset = 32'd0;
        cfg_delay = 32'd0; cfg_idx = 208'd0; cfg_dec = 1'b0;
        in_valid = 1'b0; in_char = 8'd0; out_ready = 1'b0;
        r_dout = 8'd0; r_done = 1'b0;
        for (int i = 0; i < 26; i++) idx_pat[i*8 +: 8] = 8'(25 - i);
        step(); step();
        chk_all_zero("reset");
        reset_n = 1'b1;

        // character before any configuration is never accepted
        in_valid = 1'b1; in_char = 8'd65;
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (r_valid || in_ready) nv++;
        end
        chk("no_cfg_block", 208'(nv), 208'd0);

        cfg_load = 1'b1; cfg_offset = 32'd1; cfg_delay = 32'd3;
        cfg_idx = idx_pat; cfg_dec = 1'b0;
        #1 chk("cfg_beats_valid", 208'(in_ready), 208'd0);
        step();
        cfg_load = 1'b0; in_valid = 1'b0;
        chk("r_set_on", 208'(r_set), 208'd1);
        chk("r_offset", 208'(r_offset), 208'd1);
        chk("r_delay", 208'(r_delay), 208'd3);
        chk("r_idx", r_idx, idx_pat);
        chk("r_dec_enc", 208'(r_dec), 208'd0);
        step();
        chk("r_set_off", 208'(r_set), 208'd0);
        chk("in_ready_up", 208'(in_ready), 208'd1);
        in_valid = 1'b1;
        cfg_load = 1'b1;
        #1 chk("cfg_load_masks", 208'(in_ready), 208'd0);
        cfg_load = 1'b0; in_valid = 1'b0;
        r_done = 1'b1; r_dout = 8'h99;
        step();
        r_done = 1'b0;
        chk("stray_done", 208'({out_valid, in_ready}), 208'b01);

        // 'A' with rotor answering in the third WAIT cycle
        accept(8'd65);
        chk("send_din", 208'({r_valid, r_en, r_din}), 208'({2'b10, 8'd65}));
        run_char(3, 8'h45);
        chk("A_latency", 208'(k), 208'd5);
        chk("A_rvalid_cnt", 208'(nv), 208'd1);
        chk("A_ren_cnt", 208'(ne), 208'd3);
        chk("A_out", 208'({out_valid, out_err, out_char}),
            208'({2'b10, 8'h45}));

        // backpressure: result held while out_ready is low
        hold_c = out_char; hold_e = out_err;
        nv = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (!out_valid || in_ready || out_char !== hold_c ||
                out_err !== hold_e) nv++;
        end
        chk("out_hold", 208'(nv), 208'd0);
        drain();
        chk("A_done", 208'({out_valid, in_ready}), 208'b01);

        // lowercase is rejected without touching the rotor
        accept(8'h61);
        chk("bad_out", 208'({out_valid, out_err, out_char}),
            208'({2'b11, 8'h61}));
        chk("bad_rotor", 208'({r_valid, r_en, r_din}),
            208'({2'b00, 8'd65}));
        drain();

        // '[' just above 'Z' is also rejected
        accept(8'h5B);
        chk("brk_out", 208'({out_valid, out_err, out_char}),
            208'({2'b11, 8'h5B}));
        drain();

        // rotor silent: timeout after 8 WAIT cycles
        accept(8'd66);
        run_char(100, 8'h00);
        chk("to_latency", 208'(k), 208'd10);
        chk("to_ren_cnt", 208'(ne), 208'd8);
        chk("to_out", 208'({out_valid, out_err, out_char}),
            208'({2'b11, 8'h00}));
        drain();

        // reset in the middle of WAIT
        accept(8'd67);
        step();
        chk("in_wait", 208'(r_en), 208'd1);
        reset_n = 1'b0;
        #1 chk_all_zero("midreset");
        step();
        reset_n = 1'b1;
        in_valid = 1'b1; in_char = 8'd68;
        step(); step();
        chk("need_cfg", 208'({in_ready, r_valid}), 208'd0);
        in_valid = 1'b0;

        cfg_load = 1'b1; cfg_offset = 32'd7; cfg_dec = 1'b1;
        step();
        cfg_load = 1'b0;
        step();
        chk("recfg", 208'({in_ready, r_dec, r_offset}),
            208'({2'b11, 32'd7}));

        // 'Z' upper boundary, immediate answer
        accept(8'd90);
        run_char(1, 8'h51);
        chk("Z_latency", 208'(k), 208'd3);
        chk("Z_out", 208'({out_err, out_char}), 208'({1'b0, 8'h51}));
        drain();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
